// File: rtl/inst_sram_resp.sv
// Instruction SRAM responder: translates fetch addresses, serves reads/writes from an
// internal word store after a fixed number of wait states, and flags bad requests.
module inst_sram_resp #(
    parameter int          ADDR_W      = 10,
    parameter int          WAIT_CYCLES = 0,
    parameter logic [31:0] BASE_PA     = 32'h1fc0_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inst_sram_en,
    input  logic [3:0]        inst_sram_wen,
    input  logic [31:0]       inst_sram_addr,
    input  logic [31:0]       inst_sram_wdata,
    output logic [31:0]       inst_sram_rdata,
    output logic              rdata_valid,
    output logic              resp_err,
    output logic              fetch_available,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [31:0]       load_data
);

    // state  | meaning
    // S_IDLE | no request outstanding, ready to accept
    // S_WAIT | request latched, counting down wait states
    // S_RESP | response presented this cycle, may accept the next request
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q;
    logic [ADDR_W-1:0] idx_q;
    logic [3:0]        wen_q;
    logic [31:0]       wdata_q;
    logic              err_q;
    logic [31:0]       rdata_q;
    logic              resp_err_q;

    logic [31:0]       mem [0:(1<<ADDR_W)-1];

    logic [31:0]       pa;
    logic [29:0]       off_w;
    logic              out_of_range;
    logic [ADDR_W-1:0] req_idx;
    logic              req_err;
    logic              accept;
    logic              enter_resp;
    logic [ADDR_W-1:0] cur_idx;
    logic [3:0]        cur_wen;
    logic [31:0]       cur_wdata;
    logic              cur_err;
    logic              do_write;

    always_comb begin
        pa           = (inst_sram_addr[31:30] == 2'b10) ? {3'b000, inst_sram_addr[28:0]}
                                                        : inst_sram_addr;
        off_w        = pa[31:2] - BASE_PA[31:2];
        out_of_range = (pa < BASE_PA) || ((off_w >> ADDR_W) != '0);
        req_idx      = off_w[ADDR_W-1:0];
        req_err      = out_of_range || (inst_sram_addr[1:0] != 2'b00);
    end

    assign accept = inst_sram_en && (state_q == S_IDLE || state_q == S_RESP);

    always_comb begin
        state_d    = state_q;
        enter_resp = 1'b0;
        case (state_q)
            S_IDLE, S_RESP: begin
                if (accept) begin
                    if (WAIT_CYCLES == 0) begin
                        state_d    = S_RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                    end
                end else if (state_q == S_RESP) begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd1) begin
                    state_d    = S_RESP;
                    enter_resp = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // With no wait states the response is formed from the live request, not the latches.
    always_comb begin
        if (state_q == S_WAIT) begin
            cur_idx   = idx_q;
            cur_wen   = wen_q;
            cur_wdata = wdata_q;
            cur_err   = err_q;
        end else begin
            cur_idx   = req_idx;
            cur_wen   = inst_sram_wen;
            cur_wdata = inst_sram_wdata;
            cur_err   = req_err;
        end
    end

    assign do_write = enter_resp && !rst && !cur_err && (cur_wen != 4'h0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= 4'd0;
            idx_q      <= '0;
            wen_q      <= 4'h0;
            wdata_q    <= 32'h0;
            err_q      <= 1'b0;
            rdata_q    <= 32'h0;
            resp_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                idx_q   <= req_idx;
                wen_q   <= inst_sram_wen;
                wdata_q <= inst_sram_wdata;
                err_q   <= req_err;
                cnt_q   <= 4'(WAIT_CYCLES);
            end else if (state_q == S_WAIT) begin
                cnt_q <= cnt_q - 4'd1;
            end
            if (enter_resp) begin
                rdata_q    <= (cur_err || cur_wen != 4'h0) ? 32'h0 : mem[cur_idx];
                resp_err_q <= cur_err;
            end
        end
    end

    // Store is never reset; the backdoor load wins over a request write to the same word.
    always_ff @(posedge clk) begin
        if (load_en) begin
            mem[load_addr] <= load_data;
        end
        if (do_write && !(load_en && load_addr == cur_idx)) begin
            for (int b = 0; b < 4; b++) begin
                if (cur_wen[b]) begin
                    mem[cur_idx][8*b +: 8] <= cur_wdata[8*b +: 8];
                end
            end
        end
    end

    assign rdata_valid     = !rst && (state_q == S_RESP);
    assign resp_err        = rdata_valid && resp_err_q;
    assign inst_sram_rdata = rst ? 32'h0 : rdata_q;
    assign fetch_available = !rst && (state_q == S_IDLE || state_q == S_RESP);

endmodule

// File: tb/tb_inst_sram_resp.sv
// Bench for inst_sram_resp: three instances (0, 3 and 5 wait states) driven by directed
// tables, hand-written corner sequences and random requests against a word-array model.
module tb_inst_sram_resp;

    localparam logic [31:0] BASE = 32'h1fc0_0000;
    localparam int          DEPTH = 64;

    logic        clk;
    logic        rst       [3];
    logic        en        [3];
    logic [3:0]  wen       [3];
    logic [31:0] addr      [3];
    logic [31:0] wdata     [3];
    logic [31:0] rdata     [3];
    logic        rv        [3];
    logic        err       [3];
    logic        fa        [3];
    logic        load_en   [3];
    logic [5:0]  load_addr [3];
    logic [31:0] load_data [3];

    logic [31:0] model_mem [3][DEPTH];
    logic [31:0] last_rd   [3];
    int          total = 0;
    int          bad   = 0;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        inst_sram_resp #(
            .ADDR_W(6),
            .WAIT_CYCLES(g == 0 ? 0 : (g == 1 ? 3 : 5)),
            .BASE_PA(32'h1fc0_0000)
        ) dut (
            .clk(clk),
            .rst(rst[g]),
            .inst_sram_en(en[g]),
            .inst_sram_wen(wen[g]),
            .inst_sram_addr(addr[g]),
            .inst_sram_wdata(wdata[g]),
            .inst_sram_rdata(rdata[g]),
            .rdata_valid(rv[g]),
            .resp_err(err[g]),
            .fetch_available(fa[g]),
            .load_en(load_en[g]),
            .load_addr(load_addr[g]),
            .load_data(load_data[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int wc(input int d);
        return (d == 0) ? 0 : ((d == 1) ? 3 : 5);
    endfunction

    function automatic logic [31:0] preload_val(input int i);
        return 32'h2408_0001 + 32'(i) * 32'h0001_0100;
    endfunction

    // Reference: what the responder must return for a request, updating the model store.
    function automatic void model_req(input int d, input logic [31:0] a, input logic [3:0] w,
                                      input logic [31:0] wd, output logic [31:0] er,
                                      output logic e);
        logic [31:0] p;
        longint      off;
        int          idx;
        if (a >= 32'h8000_0000 && a < 32'hC000_0000) p = a & 32'h1FFF_FFFF;
        else                                         p = a;
        off = longint'(p) - longint'(BASE);
        e   = (a % 4 != 0) || (off < 0) || (off / 4 >= DEPTH);
        er  = 32'h0;
        if (!e) begin
            idx = int'(off / 4);
            if (w == 4'h0) begin
                er = model_mem[d][idx];
            end else begin
                for (int b = 0; b < 4; b++)
                    if (w[b]) model_mem[d][idx][8*b +: 8] = wd[8*b +: 8];
            end
        end
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Called at a negedge with the DUT ready; returns at the negedge of its response cycle.
    task automatic run_req(input int d, input logic [31:0] a, input logic [3:0] w,
                           input logic [31:0] wd, input logic [31:0] er, input logic e,
                           input string name);
        chk({name, " avail"}, {31'b0, fa[d]}, 32'd1);
        en[d] = 1'b1; wen[d] = w; addr[d] = a; wdata[d] = wd;
        @(posedge clk);
        for (int k = 0; k < wc(d); k++) begin
            @(negedge clk);
            load_en[d] = 1'b0;
            en[d]      = 1'($urandom_range(0, 1));
            addr[d]    = $urandom;
            wen[d]     = 4'($urandom);
            wdata[d]   = $urandom;
            chk({name, " wait_avail"}, {31'b0, fa[d]}, 32'd0);
            chk({name, " wait_valid"}, {31'b0, rv[d]}, 32'd0);
        end
        @(negedge clk);
        load_en[d] = 1'b0; en[d] = 1'b0; wen[d] = 4'h0;
        chk({name, " valid"}, {31'b0, rv[d]}, 32'd1);
        chk({name, " rdata"}, rdata[d], er);
        chk({name, " err"}, {31'b0, err[d]}, {31'b0, e});
        last_rd[d] = er;
    endtask

    task automatic idle(input int d, input string name);
        @(negedge clk);
        en[d] = 1'b0;
        chk({name, " idle_valid"}, {31'b0, rv[d]}, 32'd0);
        chk({name, " idle_err"}, {31'b0, err[d]}, 32'd0);
        chk({name, " idle_hold"}, rdata[d], last_rd[d]);
        chk({name, " idle_avail"}, {31'b0, fa[d]}, 32'd1);
    endtask

    typedef struct {
        logic [31:0] a;
        logic [3:0]  w;
        logic [31:0] wd;
        logic [31:0] er;
        logic        e;
    } vec_t;

    vec_t tbl [12];

    initial begin
        logic [31:0] er;
        logic        e;
        logic [31:0] a;
        logic [3:0]  w;
        logic [31:0] wd;

        tbl[0]  = '{32'hbfc0_0000, 4'h0, 32'h0,         32'h2408_0001, 1'b0};
        tbl[1]  = '{32'hbfc0_0004, 4'h0, 32'h0,         32'h2409_0101, 1'b0};
        tbl[2]  = '{32'hbfc0_0002, 4'h0, 32'h0,         32'h0,         1'b1};
        tbl[3]  = '{32'h0000_0000, 4'h0, 32'h0,         32'h0,         1'b1};
        tbl[4]  = '{32'h9fc0_0008, 4'h0, 32'h0,         32'h240A_0201, 1'b0};
        tbl[5]  = '{32'h1fc0_000c, 4'h0, 32'h0,         32'h240B_0301, 1'b0};
        tbl[6]  = '{32'hbfc0_00fc, 4'h0, 32'h0,         32'h2447_3F01, 1'b0};
        tbl[7]  = '{32'hbfc0_0100, 4'h0, 32'h0,         32'h0,         1'b1};
        tbl[8]  = '{32'hbfc0_0006, 4'hF, 32'hFFFF_FFFF, 32'h0,         1'b1};
        tbl[9]  = '{32'hbfc0_0004, 4'h0, 32'h0,         32'h2409_0101, 1'b0};
        tbl[10] = '{32'hbfc0_001c, 4'hC, 32'hDEAD_BEEF, 32'h0,         1'b0};
        tbl[11] = '{32'hbfc0_001c, 4'h0, 32'h0,         32'hDEAD_0701, 1'b0};

        for (int d = 0; d < 3; d++) begin
            rst[d] = 1'b1; en[d] = 1'b0; wen[d] = 4'h0; addr[d] = 32'h0; wdata[d] = 32'h0;
            load_en[d] = 1'b0; load_addr[d] = 6'd0; load_data[d] = 32'h0; last_rd[d] = 32'h0;
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            chk("reset valid", {31'b0, rv[d]}, 32'd0);
            chk("reset err", {31'b0, err[d]}, 32'd0);
            chk("reset rdata", rdata[d], 32'h0);
            chk("reset avail", {31'b0, fa[d]}, 32'd0);
            rst[d] = 1'b0;
        end
        @(negedge clk);
        for (int d = 0; d < 3; d++) chk("post-reset avail", {31'b0, fa[d]}, 32'd1);

        for (int i = 0; i < DEPTH; i++) begin
            for (int d = 0; d < 3; d++) begin
                load_en[d] = 1'b1; load_addr[d] = 6'(i); load_data[d] = preload_val(i);
                model_mem[d][i] = preload_val(i);
            end
            @(negedge clk);
        end
        for (int d = 0; d < 3; d++) load_en[d] = 1'b0;

        for (int i = 0; i < 12; i++) begin
            model_req(0, tbl[i].a, tbl[i].w, tbl[i].wd, er, e);
            run_req(0, tbl[i].a, tbl[i].w, tbl[i].wd, tbl[i].er, tbl[i].e, $sformatf("tbl%0d", i));
            if (i % 2 == 1) idle(0, $sformatf("tbl%0d", i));
        end

        // Three back-to-back reads: consecutive response pulses in order.
        idle(0, "b2b pre");
        run_req(0, 32'hbfc0_0000, 4'h0, 32'h0, 32'h2408_0001, 1'b0, "b2b0");
        run_req(0, 32'hbfc0_0004, 4'h0, 32'h0, 32'h2409_0101, 1'b0, "b2b1");
        run_req(0, 32'hbfc0_0008, 4'h0, 32'h0, 32'h240A_0201, 1'b0, "b2b2");
        idle(0, "b2b post");

        // Partial byte write onto a known word.
        load_en[0] = 1'b1; load_addr[0] = 6'd0; load_data[0] = 32'h1122_3344;
        model_mem[0][0] = 32'h1122_3344;
        @(negedge clk);
        load_en[0] = 1'b0;
        model_req(0, 32'hbfc0_0000, 4'b0011, 32'hAABB_CCDD, er, e);
        run_req(0, 32'hbfc0_0000, 4'b0011, 32'hAABB_CCDD, 32'h0, 1'b0, "bytewr");
        model_req(0, 32'hbfc0_0000, 4'h0, 32'h0, er, e);
        run_req(0, 32'hbfc0_0000, 4'h0, 32'h0, 32'h1122_CCDD, 1'b0, "bytewr rd");

        // Backdoor load beats a same-cycle request write to the same word.
        idle(0, "prio pre");
        load_en[0] = 1'b1; load_addr[0] = 6'd5; load_data[0] = 32'h5555_AAAA;
        model_req(0, 32'hbfc0_0014, 4'hF, 32'h1234_5678, er, e);
        run_req(0, 32'hbfc0_0014, 4'hF, 32'h1234_5678, 32'h0, 1'b0, "prio wr");
        model_mem[0][5] = 32'h5555_AAAA;
        run_req(0, 32'hbfc0_0014, 4'h0, 32'h0, 32'h5555_AAAA, 1'b0, "prio rd");

        // Three wait states: avail low three cycles, response on the fourth.
        model_req(1, 32'hbfc0_0004, 4'h0, 32'h0, er, e);
        run_req(1, 32'hbfc0_0004, 4'h0, 32'h0, 32'h2409_0101, 1'b0, "wait3");
        idle(1, "wait3");

        // Reset during wait states abandons a pending write.
        chk("rstmid avail", {31'b0, fa[2]}, 32'd1);
        en[2] = 1'b1; wen[2] = 4'hF; addr[2] = 32'hbfc0_0008; wdata[2] = 32'h0BAD_0BAD;
        @(posedge clk);
        @(negedge clk);
        en[2] = 1'b0; wen[2] = 4'h0;
        @(negedge clk);
        rst[2] = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("rstmid valid", {31'b0, rv[2]}, 32'd0);
            chk("rstmid avail_low", {31'b0, fa[2]}, 32'd0);
            chk("rstmid rdata", rdata[2], 32'h0);
        end
        rst[2] = 1'b0;
        last_rd[2] = 32'h0;
        @(negedge clk);
        chk("rstmid post avail", {31'b0, fa[2]}, 32'd1);
        chk("rstmid post valid", {31'b0, rv[2]}, 32'd0);
        run_req(2, 32'hbfc0_0008, 4'h0, 32'h0, 32'h240A_0201, 1'b0, "rstmid mem");
        idle(2, "rstmid");

        for (int d = 0; d < 3; d++) begin
            for (int n = 0; n < 30; n++) begin
                int          idx;
                int          seg;
                logic [31:0] p;
                idx = $urandom_range(0, DEPTH + 6);
                p   = BASE + 32'(idx) * 32'd4;
                seg = $urandom_range(0, 4);
                case (seg)
                    0:       a = p + 32'hA000_0000;
                    1:       a = p + 32'h8000_0000;
                    2:       a = p;
                    3:       a = $urandom;
                    default: a = BASE - 32'h100 + 32'(idx) * 32'd2;
                endcase
                if ($urandom_range(0, 7) == 0) a = a + 32'($urandom_range(1, 3));
                w  = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
                wd = $urandom;
                model_req(d, a, w, wd, er, e);
                run_req(d, a, w, wd, er, e, $sformatf("rand d%0d n%0d", d, n));
                if ($urandom_range(0, 1) == 1) idle(d, "rand");
            end
            idle(d, "rand end");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/inst_sram_resp.md
INST_SRAM_RESP -- requirements
Module: inst_sram_resp

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, meaning log2 of the word depth of the internal instruction store.
REQ-002 SHALL have parameter WAIT_CYCLES, default 0, range 0..15, meaning the number of extra wait states before a response.
REQ-003 SHALL have parameter BASE_PA, default 32'h1fc0_0000, meaning the physical base address mapped to word 0.
REQ-004 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-005 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-006 SHALL have port inst_sram_en  input  1  request strobe from the fetch stage.
REQ-007 SHALL have port inst_sram_wen  input  4  byte write enables; 4'h0 means read.
REQ-008 SHALL have port inst_sram_addr  input  32  virtual byte address.
REQ-009 SHALL have port inst_sram_wdata  input  32  write data.
REQ-010 SHALL have port inst_sram_rdata  output  32  response word.
REQ-011 SHALL have port rdata_valid  output  1  one-cycle pulse qualifying inst_sram_rdata.
REQ-012 SHALL have port resp_err  output  1  qualified by rdata_valid; misaligned or out-of-range request.
REQ-013 SHALL have port fetch_available  output  1  high when a new request is accepted this cycle.
REQ-014 SHALL have ports load_en, load_addr (ADDR_W), load_data (32), all inputs, forming a bench backdoor word-write port.

Function
REQ-015 SHALL translate addresses: kseg0/kseg1 (addr[31:30]==2'b10) clear addr[31:29]; other addresses pass unchanged.
REQ-016 SHALL compute the word index as (PA - BASE_PA) >> 2; out of range when PA < BASE_PA or index >= 2^ADDR_W.
REQ-017 SHALL flag misalignment when addr[1:0] != 2'b00.
REQ-018 SHALL implement the states IDLE, WAIT and RESP.
REQ-019 SHALL accept a request in IDLE when inst_sram_en=1, with fetch_available=1 in IDLE.
REQ-020 SHALL, on acceptance, latch the index, wen, wdata and error flag.
REQ-021 SHALL go to RESP when WAIT_CYCLES=0; otherwise it SHALL load the counter with WAIT_CYCLES and go to WAIT.
REQ-022 SHALL, in WAIT, decrement the counter each cycle and go to RESP in the cycle after the counter reaches 1.
REQ-023 SHALL, in RESP, assert rdata_valid for exactly one cycle, with read latency from acceptance equal to 1+WAIT_CYCLES cycles.
REQ-024 SHALL drive fetch_available=1 in RESP, so that a back-to-back request is accepted in the RESP cycle.
REQ-025 SHALL move RESP to WAIT or RESP when a new request is accepted, and RESP to IDLE otherwise.
REQ-026 SHALL, for an accepted read with no error, return the stored word at the latched index.
REQ-027 SHALL, for an accepted write with no error, update only the bytes enabled by wen when entering RESP, and return 32'h0.
REQ-028 SHALL, for an errored request, return rdata=32'h0 with resp_err=1, leave memory unchanged and suppress any write.
REQ-029 SHALL hold fetch_available=0 in WAIT and SHALL ignore inst_sram_en there.
REQ-030 SHALL make load_en write load_data to word load_addr in one cycle, with priority over a same-cycle request write to the same word.
REQ-031 SHALL hold inst_sram_rdata at its last value when rdata_valid=0, with resp_err=0 then.
REQ-032 SHALL never produce X on any output after reset, even when the memory is uninitialised (bench preloads it).

Reset
REQ-033 SHALL, while rst=1, go to IDLE, clear the counter, and drive rdata_valid=0, resp_err=0, inst_sram_rdata=32'h0 and fetch_available=0.
REQ-034 SHALL, when rst asserts mid-transaction, abandon the transaction with no response pulse and no memory write.
REQ-035 SHALL leave memory contents unchanged on reset.
REQ-036 SHALL set fetch_available=1 in the first cycle after rst deasserts.

Verification
REQ-037 SHALL be verified by: WAIT_CYCLES=0, preload word0=32'h2408_0001, read addr 32'hbfc0_0000 -> rdata_valid next cycle, rdata=32'h2408_0001, resp_err=0.
REQ-038 SHALL be verified by: WAIT_CYCLES=3, read 32'hbfc0_0004 -> fetch_available low for 3 cycles, rdata_valid at cycle 4 after acceptance.
REQ-039 SHALL be verified by: back-to-back reads of 0xbfc0_0000, 0xbfc0_0004 and 0xbfc0_0008 with WAIT_CYCLES=0 -> three consecutive rdata_valid pulses in order.
REQ-040 SHALL be verified by: a read at 32'hbfc0_0002 and a read at 32'h0000_0000 -> each gives rdata=0 and resp_err=1.
REQ-041 SHALL be verified by: a write with wen=4'b0011 and wdata=32'hAABB_CCDD to word0 holding 32'h1122_3344, then a read -> 32'h1122_CCDD.
REQ-042 SHALL be verified by: rst asserted in WAIT with WAIT_CYCLES=5 -> no rdata_valid, memory unchanged, and fetch_available=1 in the cycle after rst deasserts.
